// File: rtl/ota_bitstream_decimator.sv
// Synchronises the OTA comparator bit, decimates it over 2^LOG2_WIN cycles into a density sample and counts transitions per window.
// Build option: define OTA_DEC_DEGLITCH_EN to feed the decimator from a registered 3-tap majority of the synchronised bit.
module ota_bitstream_decimator #(
    parameter int LOG2_WIN = 8,
    parameter int OUT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             ota_in,
    input  logic             run,
    output logic [OUT_W-1:0] sample,
    output logic             sample_valid,
    output logic [7:0]       toggles,
    output logic             busy
);
    // state  | meaning
    // IDLE   | counters cleared, waiting for run
    // SETTLE | 4 cycles flushing synchroniser and deglitch pipeline
    // ACCUM  | counting ones and transitions over one window
    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    localparam int N = 1 << LOG2_WIN;
    localparam int SHIFT = LOG2_WIN - OUT_W;
    localparam logic [LOG2_WIN:0] ONES_MAX = (LOG2_WIN + 1)'(N - 1);

    state_t              state;
    logic                s_meta;
    logic                s;
    logic                d;
    logic                d_prev;
    logic [1:0]          settle_cnt;
    logic [LOG2_WIN-1:0] phase;
    logic [LOG2_WIN:0]   ones;
    logic [LOG2_WIN:0]   ones_next;
    logic [LOG2_WIN:0]   ones_sat;
    logic [7:0]          tog;
    logic [7:0]          tog_next;
    logic                last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else if (ena) begin
            s_meta <= ota_in;
            s      <= s_meta;
        end
    end

`ifdef OTA_DEC_DEGLITCH_EN
    logic s_h1;
    logic s_h2;
    logic d_maj;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_h1  <= 1'b0;
            s_h2  <= 1'b0;
            d_maj <= 1'b0;
        end else if (ena) begin
            s_h1  <= s;
            s_h2  <= s_h1;
            d_maj <= (s & s_h1) | (s & s_h2) | (s_h1 & s_h2);
        end
    end

    assign d = d_maj;
`else
    assign d = s;
`endif

    // The first bit of each window has no in-window predecessor, so it never counts as a toggle.
    always_comb begin
        ones_next = ones + {{LOG2_WIN{1'b0}}, d};
        ones_sat  = (ones_next > ONES_MAX) ? ONES_MAX : ones_next;
        tog_next  = tog;
        if ((phase != '0) && (d != d_prev) && (tog != 8'hFF)) begin
            tog_next = tog + 8'd1;
        end
        last_bit = (phase == '1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= 2'd0;
            phase        <= '0;
            ones         <= '0;
            tog          <= 8'd0;
            d_prev       <= 1'b0;
            sample       <= '0;
            toggles      <= 8'd0;
            sample_valid <= 1'b0;
        end else if (!ena) begin
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    ones  <= '0;
                    tog   <= 8'd0;
                    if (run) begin
                        state      <= SETTLE;
                        settle_cnt <= 2'd3;
                    end
                end
                SETTLE: begin
                    if (!run) begin
                        state <= IDLE;
                    end else if (settle_cnt == 2'd0) begin
                        state <= ACCUM;
                        phase <= '0;
                        ones  <= '0;
                        tog   <= 8'd0;
                    end else begin
                        settle_cnt <= settle_cnt - 2'd1;
                    end
                end
                ACCUM: begin
                    d_prev <= d;
                    if (last_bit) begin
                        sample       <= OUT_W'(ones_sat >> SHIFT);
                        toggles      <= tog_next;
                        sample_valid <= 1'b1;
                        phase        <= '0;
                        ones         <= '0;
                        tog          <= 8'd0;
                        state        <= run ? ACCUM : IDLE;
                    end else if (!run) begin
                        state <= IDLE;
                        phase <= '0;
                        ones  <= '0;
                        tog   <= 8'd0;
                    end else begin
                        phase <= phase + LOG2_WIN'(1);
                        ones  <= ones_next;
                        tog   <= tog_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SETTLE) || (state == ACCUM);
endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Self-checking bench for ota_bitstream_decimator: directed runs with patterned and random bit streams against a window-level reference model.
module tb_ota_bitstream_decimator;
    localparam int LOG2_WIN = 8;
    localparam int OUT_W    = 8;
    localparam int N        = 1 << LOG2_WIN;
`ifdef OTA_DEC_DEGLITCH_EN
    localparam int GLITCH_EXP = 0;
`else
    localparam int GLITCH_EXP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ena = 1'b0;
    logic             ota_in = 1'b0;
    logic             run = 1'b0;
    logic [OUT_W-1:0] sample;
    logic             sample_valid;
    logic [7:0]       toggles;
    logic             busy;

    ota_bitstream_decimator #(.LOG2_WIN(LOG2_WIN), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ota_in(ota_in), .run(run),
        .sample(sample), .sample_valid(sample_valid), .toggles(toggles), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_idx = 0;
    int base = 0;
    int e0 = 0;
    int next_end = 0;
    int start_cyc = 0;
    int first_strobe_cyc = 0;
    int last_period = 0;
    int glitch_e = -1;
    bit xarr [0:16383];
    int exp_sample = 0;
    int exp_tog = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // ota_in as captured on enabled clock edge i; anything before the last reset reads as 0.
    function automatic bit getx(input int i);
        if (i < 0 || i < base) return 1'b0;
        return xarr[i];
    endfunction

    // Bit seen by the decimator on enabled edge e: two-flop delay, or majority of three older samples.
    function automatic bit dbit(input int e);
`ifdef OTA_DEC_DEGLITCH_EN
        int sum;
        sum = int'(getx(e - 3)) + int'(getx(e - 4)) + int'(getx(e - 5));
        return sum >= 2;
`else
        return getx(e - 2);
`endif
    endfunction

    task automatic model_window(input int first_e, output int es, output int et);
        int ones = 0;
        int tg = 0;
        bit b;
        bit p = 1'b0;
        for (int j = 0; j < N; j++) begin
            b = dbit(first_e + j);
            ones += int'(b);
            if (j > 0 && b != p) tg++;
            p = b;
        end
        es = ((ones > N - 1) ? N - 1 : ones) >> (LOG2_WIN - OUT_W);
        et = (tg > 255) ? 255 : tg;
    endtask

    function automatic bit next_ota(input int mode, input int e);
        int pos;
        pos = (((e + 2 - (e0 + 5)) % N) + N) % N;
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return pos < 64;
            3: return e[0];
            4: return 1'($urandom % 2);
            default: return e == glitch_e;
        endcase
    endfunction

    task automatic tick();
        bit cx;
        bit ce;
        cx = ota_in;
        ce = ena;
        @(posedge clk);
        cyc++;
        if (ce) begin
            xarr[en_idx] = cx;
            en_idx++;
        end
        #1;
    endtask

    task automatic idle(input int n);
        run = 1'b0;
        repeat (n) begin
            ota_in = 1'($urandom % 2);
            tick();
            chk("idle_strobe", sample_valid, 0);
            chk("idle_busy", busy, 0);
            chk("idle_sample_hold", sample, exp_sample);
        end
    endtask

    task automatic start_run();
        e0 = en_idx;
        next_end = e0 + 260;
        start_cyc = cyc + 1;
    endtask

    task automatic run_windows(input int mode, input int nwin, input bit stop_last,
                               input int gap_at, input int gap_len);
        int done = 0;
        int es;
        int et;
        int prev_strobe = -1;
        while (done < nwin) begin
            if (gap_at >= 0 && en_idx == gap_at) begin
                ena = 1'b0;
                repeat (gap_len) begin
                    ota_in = 1'($urandom % 2);
                    tick();
                    chk("gap_strobe", sample_valid, 0);
                    chk("gap_busy", busy, 1);
                end
                ena = 1'b1;
                gap_at = -1;
            end
            ota_in = next_ota(mode, en_idx);
            run = !(stop_last && done == nwin - 1 && en_idx == next_end);
            tick();
            if (en_idx - 1 == next_end) begin
                model_window(next_end - (N - 1), es, et);
                chk("strobe", sample_valid, 1);
                chk("sample", sample, es);
                chk("toggles", toggles, et);
                chk("busy_at_end", busy, (stop_last && done == nwin - 1) ? 0 : 1);
                if (prev_strobe < 0) first_strobe_cyc = cyc;
                else last_period = cyc - prev_strobe;
                prev_strobe = cyc;
                exp_sample = es;
                exp_tog = et;
                next_end += N;
                done++;
            end else begin
                chk("no_strobe", sample_valid, 0);
                chk("busy_run", busy, 1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #23;
        chk("rst_sample", sample, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_toggles", toggles, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        idle(4);

        // constant one: saturated sample, first strobe 260 edges after run is sampled
        start_run();
        run_windows(0, 2, 1'b1, -1, 0);
        chk("ones_sample", sample, 255);
        chk("ones_toggles", toggles, 0);
        chk("first_latency", first_strobe_cyc - start_cyc, 260);
        chk("strobe_period", last_period, 256);
        idle(3);

        start_run();
        run_windows(1, 1, 1'b1, -1, 0);
        chk("zeros_sample", sample, 0);
        chk("zeros_toggles", toggles, 0);
        idle(3);

        start_run();
        run_windows(2, 2, 1'b1, -1, 0);
        chk("block_sample", sample, 64);
        idle(3);

        start_run();
        run_windows(3, 1, 1'b1, -1, 0);
        chk("alt_sample", sample, 128);
        chk("alt_toggles", toggles, 255);
        idle(3);

        start_run();
        run_windows(4, 3, 1'b1, -1, 0);
        idle(3);

        // abort at ACCUM phase 100
        start_run();
        for (int i = 0; i < 105; i++) begin
            ota_in = 1'($urandom % 2);
            run = 1'b1;
            tick();
            chk("abort_pre_strobe", sample_valid, 0);
        end
        run = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_strobe", sample_valid, 0);
        idle(300);
        chk("abort_sample_hold", sample, exp_sample);
        chk("abort_toggles_hold", toggles, exp_tog);
        start_run();
        run_windows(4, 1, 1'b1, -1, 0);
        idle(3);

        // ena low for 50 cycles mid-window
        start_run();
        run_windows(0, 1, 1'b1, e0 + 100, 50);
        chk("ena_gap_latency", first_strobe_cyc - start_cyc, 310);
        chk("ena_gap_sample", sample, 255);
        idle(3);

        // async reset mid-window
        start_run();
        for (int i = 0; i < 100; i++) begin
            ota_in = 1'b1;
            run = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sample", sample, 0);
        chk("arst_valid", sample_valid, 0);
        chk("arst_toggles", toggles, 0);
        chk("arst_busy", busy, 0);
        run = 1'b0;
        #3 rst_n = 1'b1;
        base = en_idx;
        exp_sample = 0;
        exp_tog = 0;
        idle(5);

        // single-cycle glitch in a zero stream
        start_run();
        glitch_e = e0 + 131;
        run_windows(5, 1, 1'b1, -1, 0);
        chk("glitch_sample", sample, GLITCH_EXP);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
